agu_pipe: RTL

Registered, parametrised address generation unit for the execute stage. It computes load/store, branch, jump and jump-register target addresses from a base and an offset. It checks alignment per access size and holds the result in one pipeline register with valid/stall/flush control. It also captures the first faulting address in a sticky bad-address register for the exception logic.

---
 rtl/agu_pipe.sv | 95 +++++++++
 1 files changed

// File: rtl/agu_pipe.sv
// rtl/agu_pipe.sv - execute-stage address generation unit with one output register
// Computes jr/load-store/branch/jump targets, checks alignment, and keeps a sticky first-fault address.
module agu_pipe #(
  parameter int NBITS       = 32,
  parameter int IMM_BITS    = 16,
  parameter int OFFSET_BITS = 26
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [3:0]             i_op_code,
  input  logic [1:0]             i_size,
  input  logic [NBITS-1:0]       i_addr,
  input  logic [OFFSET_BITS-1:0] i_offset,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_exc_clear,
  output logic                   o_valid,
  output logic [NBITS-1:0]       o_eff_addr,
  output logic [1:0]             o_exc_code,
  output logic                   o_exc_pending,
  output logic [NBITS-1:0]       o_bad_addr
);

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_LS   = 2'b01;
  localparam logic [1:0] EXC_JR   = 2'b10;
  localparam logic [1:0] EXC_ILL  = 2'b11;

  logic [NBITS-1:0] imm_ext;
  logic [NBITS-1:0] eff;
  logic [1:0]       exc;
  logic             load;
  logic             capture;

  assign imm_ext = {{(NBITS-IMM_BITS){i_offset[IMM_BITS-1]}}, i_offset[IMM_BITS-1:0]};

  always_comb begin
    eff = '0;
    exc = EXC_NONE;
    case (i_op_code)
      4'b0000: begin
        eff = i_addr;
        if (eff[1:0] != 2'b00) exc = EXC_JR;
      end
      4'b0001: begin
        eff = i_addr + imm_ext;
        // size 11 is treated as a word access
        case (i_size)
          2'b00:   exc = EXC_NONE;
          2'b01:   exc = eff[0] ? EXC_LS : EXC_NONE;
          default: exc = (eff[1:0] != 2'b00) ? EXC_LS : EXC_NONE;
        endcase
      end
      4'b0010: eff = i_addr + (imm_ext << 2);
      4'b0011: eff = {i_addr[NBITS-1:OFFSET_BITS+2], i_offset, 2'b00};
      default: begin
        eff = '0;
        exc = EXC_ILL;
      end
    endcase
  end

  assign load    = !i_flush && !i_stall;
  assign capture = load && i_valid && (exc != EXC_NONE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid    <= 1'b0;
      o_eff_addr <= '0;
      o_exc_code <= EXC_NONE;
    end else if (i_flush) begin
      o_valid    <= 1'b0;
      o_exc_code <= EXC_NONE;
    end else if (!i_stall) begin
      o_valid    <= i_valid;
      o_eff_addr <= eff;
      o_exc_code <= i_valid ? exc : EXC_NONE;
    end
  end

  // First fault wins unless a clear arrives with the new fault in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_exc_pending <= 1'b0;
      o_bad_addr    <= '0;
    end else if (capture && (!o_exc_pending || i_exc_clear)) begin
      o_exc_pending <= 1'b1;
      o_bad_addr    <= eff;
    end else if (!capture && i_exc_clear) begin
      o_exc_pending <= 1'b0;
    end
  end

endmodule
